axi_ddr_slave_model: RTL and testbench
======================================

Name: axi_ddr_slave_model

Overview:
- Synthesizable AXI4 slave with an internal RAM. Sits directly downstream of the AXI master/driver and stands in for the DDR3 memory controller in simulation and bring-up.
- Accepts write and read bursts on the s_axi_* channels and stores data in a word-addressed array.
- Produces init_calib_complete after a programmable delay, mimicking controller calibration.

Parameters:
- C_S_AXI_ID_WIDTH, 4, AXI ID width
- C_S_AXI_ADDR_WIDTH, 32, byte address width
- C_S_AXI_DATA_WIDTH, 512, data width; bytes per word BPW = C_S_AXI_DATA_WIDTH/8
- MEM_DEPTH_LOG2, 10, log2 of RAM depth in words
- CALIB_CYCLES, 100, cycles from reset release to init_calib_complete

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous active-high reset
- init_calib_complete  out  1  high once calibration delay has elapsed
- s_axi_awid  in  ID  write ID
- s_axi_awaddr  in  ADDR  write byte address
- s_axi_awlen  in  8  beats-1
- s_axi_awsize  in  3  beat size
- s_axi_awburst  in  2  burst type
- s_axi_awvalid  in  1  AW valid
- s_axi_awready  out  1  AW ready
- s_axi_wdata  in  DATA  write data
- s_axi_wstrb  in  DATA/8  byte enables
- s_axi_wlast  in  1  last beat
- s_axi_wvalid  in  1  W valid
- s_axi_wready  out  1  W ready
- s_axi_bid  out  ID  response ID
- s_axi_bresp  out  2  response code
- s_axi_bvalid  out  1  B valid
- s_axi_bready  in  1  B ready
- s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid  in  as AW  read address channel
- s_axi_arready  out  1  AR ready
- s_axi_rid  out  ID  read ID
- s_axi_rdata  out  DATA  read data
- s_axi_rresp  out  2  read response
- s_axi_rlast  out  1  last read beat
- s_axi_rvalid  out  1  R valid
- s_axi_rready  in  1  R ready

Behaviour:
- Reset (sync, rst=1 at posedge): all outputs 0; calibration counter cleared; write FSM to W_IDLE, read FSM to R_IDLE. RAM contents are not cleared.
- Reset mid-burst abandons the burst with no B or R response. Calibration restarts.
- Calibration: counter increments each cycle after reset. init_calib_complete rises on the cycle the count reaches CALIB_CYCLES and stays high until the next rst.
- Word index = addr[log2(BPW) +: MEM_DEPTH_LOG2]. Upper address bits are ignored, so accesses wrap modulo the RAM depth.
- Supported transfer: burst FIXED (00) or INCR (01) with size == log2(BPW).
  - Any other burst or size is an error: data beats are still consumed/produced, writes are discarded, reads return 0, and resp=SLVERR (2'b10).
  - Otherwise resp=OKAY.
- INCR increments the word index per beat, wrapping at MEM_DEPTH. FIXED holds the index.
- Write FSM:
  - W_IDLE: awready = init_calib_complete. On AW handshake, latch id/index/len/burst/err and go to W_DATA.
  - W_DATA: wready=1. Each W handshake writes the bytes enabled by wstrb and increments the beat counter.
  - The beat with counter==len ends the burst and the FSM goes to W_RESP. If wlast disagrees with counter==len on any beat, the response is forced to SLVERR. The burst always ends after exactly len+1 beats.
  - W_RESP: bvalid=1, bid=latched id. Hold until bready, then go to W_IDLE.
- Read FSM:
  - R_IDLE: arready = init_calib_complete. On AR handshake, latch fields and go to R_FETCH.
  - R_FETCH: registered RAM read of the first word, then go to R_DATA.
  - R_DATA: rvalid=1, rid=latched id, rlast=(beat==len).
    - On R handshake with !rlast, the next word is read in the same cycle, giving one beat per cycle under continuous rready.
    - On the rlast handshake, go to R_IDLE.
    - rdata, rlast and rresp are stable while rvalid && !rready.
  - Latency: AR handshake at cycle N gives first rvalid at N+2.
- Write and read channels are fully independent. A same-cycle write and read to the same word returns the pre-write data.
- Only one outstanding write and one outstanding read at a time: awready=0 outside W_IDLE, arready=0 outside R_IDLE.

Test Plan:
- Release rst with CALIB_CYCLES=100 -> init_calib_complete rises exactly 100 cycles later; awready=arready=0 before that.
- Write len=0, size=6, burst=INCR, addr=0x40, data=D, wstrb all-ones; then read the same address -> bresp=OKAY, bid echoed; rdata=D with rlast=1; rvalid 2 cycles after the AR handshake.
- Write 3-beat INCR at 0x80 with D0..D2; read len=2 from 0x80 with rready held high -> D0,D1,D2 on consecutive cycles, rlast only on D2. Repeat with rready toggling every other cycle -> same data, with rdata held steady while stalled.
- Write wstrb=64'h00000000_0000FFFF over an existing word -> only bytes 0..15 change on readback.
- burst=WRAP (10), or wlast asserted on beat 0 of a len=2 burst -> bresp=SLVERR; for WRAP the RAM is unchanged; exactly 3 beats are consumed in both cases.
- Assert rst during W_DATA beat 1 -> all outputs 0 next cycle, no bvalid; after recalibration a fresh write/read completes normally.

Source files
------------

// File: rtl/axi_ddr_slave_model.sv
// AXI4 slave backed by an on-chip word-addressed RAM. Stands in for a DDR3
// controller: one outstanding write and one outstanding read, independent
// channels, and a calibration-done flag that rises a fixed time after reset.
module axi_ddr_slave_model #(
    parameter int C_S_AXI_ID_WIDTH   = 4,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 512,
    parameter int MEM_DEPTH_LOG2     = 10,
    parameter int CALIB_CYCLES       = 100
) (
    input  logic                            clk,
    input  logic                            rst,
    output logic                            init_calib_complete,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_awid,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]                      s_axi_awlen,
    input  logic [2:0]                      s_axi_awsize,
    input  logic [1:0]                      s_axi_awburst,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wlast,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_arid,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]                      s_axi_arlen,
    input  logic [2:0]                      s_axi_arsize,
    input  logic [1:0]                      s_axi_arburst,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_rid,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rlast,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready
);
    localparam int BPW       = C_S_AXI_DATA_WIDTH / 8;
    localparam int OFF       = $clog2(BPW);
    localparam int MEM_DEPTH = 1 << MEM_DEPTH_LOG2;
    localparam int CW        = $clog2(CALIB_CYCLES + 1);
    localparam logic [2:0] FULL_SIZE = 3'(OFF);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;
    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_FETCH = 2'd1;
    localparam logic [1:0] R_DATA  = 2'd2;

    logic [C_S_AXI_DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    logic [CW-1:0] cnt_q;
    logic          calib_q;

    logic [1:0]                    w_state_q;
    logic [C_S_AXI_ID_WIDTH-1:0]   bid_q;
    logic [1:0]                    bresp_q;
    logic [MEM_DEPTH_LOG2-1:0]     w_idx_q, w_idx_d;
    logic [7:0]                    w_len_q, w_beat_q;
    logic                          w_incr_q, w_err_q, w_bad_q;

    logic [1:0]                    r_state_q;
    logic [C_S_AXI_ID_WIDTH-1:0]   rid_q;
    logic [1:0]                    rresp_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
    logic [MEM_DEPTH_LOG2-1:0]     r_idx_q, r_idx_d;
    logic [7:0]                    r_len_q, r_beat_q;
    logic                          r_incr_q, r_err_q;

    logic aw_hs, w_hs, ar_hs, r_hs, aw_err, ar_err, r_last;

    // Address bits above the RAM index are intentionally ignored (wrap).
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, s_axi_awaddr, s_axi_araddr};

    assign aw_hs  = s_axi_awvalid && s_axi_awready;
    assign w_hs   = s_axi_wvalid && s_axi_wready;
    assign ar_hs  = s_axi_arvalid && s_axi_arready;
    assign r_hs   = s_axi_rvalid && s_axi_rready;
    assign aw_err = !(s_axi_awburst == 2'b00 || s_axi_awburst == 2'b01) || (s_axi_awsize != FULL_SIZE);
    assign ar_err = !(s_axi_arburst == 2'b00 || s_axi_arburst == 2'b01) || (s_axi_arsize != FULL_SIZE);
    assign w_idx_d = w_incr_q ? w_idx_q + 1'b1 : w_idx_q;
    assign r_idx_d = r_incr_q ? r_idx_q + 1'b1 : r_idx_q;
    assign r_last  = (r_beat_q == r_len_q);

    assign init_calib_complete = calib_q;
    assign s_axi_awready = (w_state_q == W_IDLE) && calib_q;
    assign s_axi_wready  = (w_state_q == W_DATA);
    assign s_axi_bvalid  = (w_state_q == W_RESP);
    assign s_axi_bid     = bid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = (r_state_q == R_IDLE) && calib_q;
    assign s_axi_rvalid  = (r_state_q == R_DATA);
    assign s_axi_rlast   = (r_state_q == R_DATA) && r_last;
    assign s_axi_rid     = rid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;

    // Calibration delay: count cycles since reset, then latch the done flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            calib_q <= 1'b0;
        end else if (!calib_q) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CW'(CALIB_CYCLES - 1)) calib_q <= 1'b1;
        end
    end

    // Write FSM: accept one burst, consume exactly len+1 beats, respond.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            bid_q     <= '0;
            bresp_q   <= RESP_OKAY;
            w_idx_q   <= '0;
            w_len_q   <= '0;
            w_beat_q  <= '0;
            w_incr_q  <= 1'b0;
            w_err_q   <= 1'b0;
            w_bad_q   <= 1'b0;
        end else begin
            case (w_state_q)
                W_IDLE: if (aw_hs) begin
                    bid_q     <= s_axi_awid;
                    w_idx_q   <= s_axi_awaddr[OFF +: MEM_DEPTH_LOG2];
                    w_len_q   <= s_axi_awlen;
                    w_beat_q  <= '0;
                    w_incr_q  <= (s_axi_awburst == 2'b01);
                    w_err_q   <= aw_err;
                    w_bad_q   <= 1'b0;
                    w_state_q <= W_DATA;
                end
                W_DATA: if (w_hs) begin
                    w_beat_q <= w_beat_q + 1'b1;
                    w_idx_q  <= w_idx_d;
                    if (w_beat_q == w_len_q) begin
                        // A missing wlast on the final beat is also a protocol error.
                        bresp_q   <= (w_err_q || w_bad_q || !s_axi_wlast) ? RESP_SLVERR : RESP_OKAY;
                        w_state_q <= W_RESP;
                    end else if (s_axi_wlast) begin
                        w_bad_q <= 1'b1;
                    end
                end
                W_RESP: if (s_axi_bready) w_state_q <= W_IDLE;
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    // RAM write port with byte enables; erroneous bursts never touch the RAM.
    always_ff @(posedge clk) begin
        if (!rst && (w_state_q == W_DATA) && w_hs && !w_err_q) begin
            for (int b = 0; b < BPW; b++) begin
                if (s_axi_wstrb[b]) mem_q[w_idx_q][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
            end
        end
    end

    // Read FSM with registered RAM read; next word is prefetched on each accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            rid_q     <= '0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            r_idx_q   <= '0;
            r_len_q   <= '0;
            r_beat_q  <= '0;
            r_incr_q  <= 1'b0;
            r_err_q   <= 1'b0;
        end else begin
            case (r_state_q)
                R_IDLE: if (ar_hs) begin
                    rid_q     <= s_axi_arid;
                    r_idx_q   <= s_axi_araddr[OFF +: MEM_DEPTH_LOG2];
                    r_len_q   <= s_axi_arlen;
                    r_beat_q  <= '0;
                    r_incr_q  <= (s_axi_arburst == 2'b01);
                    r_err_q   <= ar_err;
                    rresp_q   <= ar_err ? RESP_SLVERR : RESP_OKAY;
                    r_state_q <= R_FETCH;
                end
                R_FETCH: begin
                    rdata_q   <= r_err_q ? '0 : mem_q[r_idx_q];
                    r_state_q <= R_DATA;
                end
                R_DATA: if (r_hs) begin
                    if (r_last) begin
                        r_state_q <= R_IDLE;
                    end else begin
                        r_beat_q <= r_beat_q + 1'b1;
                        r_idx_q  <= r_idx_d;
                        rdata_q  <= r_err_q ? '0 : mem_q[r_idx_d];
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_ddr_slave_model.sv
// Directed bench for axi_ddr_slave_model: calibration, single and burst
// transfers, byte strobes, error bursts and reset in the middle of a burst.
module tb_axi_ddr_slave_model;
    logic         clk = 1'b0;
    logic         rst;
    logic         init_calib_complete;
    logic [3:0]   s_axi_awid;
    logic [31:0]  s_axi_awaddr;
    logic [7:0]   s_axi_awlen;
    logic [2:0]   s_axi_awsize;
    logic [1:0]   s_axi_awburst;
    logic         s_axi_awvalid, s_axi_awready;
    logic [511:0] s_axi_wdata;
    logic [63:0]  s_axi_wstrb;
    logic         s_axi_wlast, s_axi_wvalid, s_axi_wready;
    logic [3:0]   s_axi_bid;
    logic [1:0]   s_axi_bresp;
    logic         s_axi_bvalid, s_axi_bready;
    logic [3:0]   s_axi_arid;
    logic [31:0]  s_axi_araddr;
    logic [7:0]   s_axi_arlen;
    logic [2:0]   s_axi_arsize;
    logic [1:0]   s_axi_arburst;
    logic         s_axi_arvalid, s_axi_arready;
    logic [3:0]   s_axi_rid;
    logic [511:0] s_axi_rdata;
    logic [1:0]   s_axi_rresp;
    logic         s_axi_rlast, s_axi_rvalid, s_axi_rready;

    int tests = 0;
    int fails = 0;
    logic [511:0] wd [4];
    logic [511:0] rd [4];
    logic         rl [4];

    axi_ddr_slave_model dut (
        .clk(clk), .rst(rst), .init_calib_complete(init_calib_complete),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full write transaction; wlast is driven on beat index last_at.
    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input int last_at, input logic [63:0] strb,
                            output logic [1:0] resp, output logic [3:0] bid_o, output int beats);
        int guard;
        int b;
        logic hs;
        s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len;
        s_axi_awsize = 3'd6; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
        guard = 0;
        while (!s_axi_awready && guard < 300) begin
            @(posedge clk); #1; guard++;
        end
        chk("aw_ready_timeout", 512'(guard < 300), 512'(1));
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
        b = 0; guard = 0;
        while (!s_axi_bvalid && guard < 30) begin
            s_axi_wvalid = 1'b1;
            s_axi_wdata  = wd[b % 4];
            s_axi_wstrb  = strb;
            s_axi_wlast  = (b == last_at);
            hs = s_axi_wready;
            @(posedge clk); #1; guard++;
            if (hs) b++;
        end
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
        beats = b;
        chk("b_valid", 512'(s_axi_bvalid), 512'(1));
        resp = s_axi_bresp; bid_o = s_axi_bid;
        s_axi_bready = 1'b1;
        @(posedge clk); #1;
        s_axi_bready = 1'b0;
        chk("b_done", 512'(s_axi_bvalid), 512'(0));
    endtask

    // Full read transaction; checks N+2 latency and data hold while stalled.
    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input bit toggle,
                           output logic [1:0] resp, output logic [3:0] rid_o, output int cycles);
        int guard;
        int k;
        logic v, l, phase;
        logic [511:0] d;
        s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
        s_axi_arsize = 3'd6; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
        guard = 0;
        while (!s_axi_arready && guard < 300) begin
            @(posedge clk); #1; guard++;
        end
        chk("ar_ready_timeout", 512'(guard < 300), 512'(1));
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
        chk("r_latency_n1", 512'(s_axi_rvalid), 512'(0));
        @(posedge clk); #1;
        chk("r_latency_n2", 512'(s_axi_rvalid), 512'(1));
        k = 0; cycles = 0; phase = 1'b0;
        resp = 2'bxx; rid_o = 4'bx;
        while (k <= int'(len) && cycles < 40) begin
            s_axi_rready = toggle ? phase : 1'b1;
            phase = ~phase;
            v = s_axi_rvalid; d = s_axi_rdata; l = s_axi_rlast;
            if (v && s_axi_rready) begin
                rd[k] = d; rl[k] = l; resp = s_axi_rresp; rid_o = s_axi_rid; k++;
            end
            @(posedge clk); #1; cycles++;
            if (v && !s_axi_rready) begin
                chk("r_hold_data", s_axi_rdata, d);
                chk("r_hold_last", 512'(s_axi_rlast), 512'(l));
            end
        end
        s_axi_rready = 1'b0;
        chk("r_back_idle", 512'(s_axi_rvalid), 512'(0));
    endtask

    initial begin : main
        logic [511:0] d, d0, d1, d2, e, m;
        logic [1:0] resp;
        logic [3:0] idv;
        int beats, cycles, n;
        logic saw_b;

        rst = 1'b1;
        s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0;
        s_axi_awburst = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b0;
        s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0;
        s_axi_arburst = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
        d  = {16{32'hDEAD_0001}};
        d0 = {16{32'hA0A0_1000}};
        d1 = {16{32'hB1B1_2001}};
        d2 = {16{32'hC2C2_3002}};
        e  = {16{32'h1111_2222}};

        // Reset state and calibration delay
        repeat (3) @(posedge clk);
        #1;
        chk("rst_calib", 512'(init_calib_complete), 512'(0));
        chk("rst_awready", 512'(s_axi_awready), 512'(0));
        chk("rst_bvalid", 512'(s_axi_bvalid), 512'(0));
        chk("rst_rvalid", 512'(s_axi_rvalid), 512'(0));
        chk("rst_rdata", s_axi_rdata, 512'(0));
        rst = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (k == 99) begin
                chk("calib_99", 512'(init_calib_complete), 512'(0));
                chk("awready_99", 512'(s_axi_awready), 512'(0));
                chk("arready_99", 512'(s_axi_arready), 512'(0));
            end
            if (k == 100) begin
                chk("calib_100", 512'(init_calib_complete), 512'(1));
                chk("awready_100", 512'(s_axi_awready), 512'(1));
                chk("arready_100", 512'(s_axi_arready), 512'(1));
            end
        end

        // Single-beat write then read at 0x40
        wd[0] = d;
        do_write(4'd5, 32'h40, 8'd0, 2'b01, 0, {64{1'b1}}, resp, idv, beats);
        chk("w1_bresp", 512'(resp), 512'(2'b00));
        chk("w1_bid", 512'(idv), 512'(4'd5));
        chk("w1_beats", 512'(beats), 512'(1));
        do_read(4'd3, 32'h40, 8'd0, 2'b01, 1'b0, resp, idv, cycles);
        chk("r1_data", rd[0], d);
        chk("r1_last", 512'(rl[0]), 512'(1));
        chk("r1_rresp", 512'(resp), 512'(2'b00));
        chk("r1_rid", 512'(idv), 512'(4'd3));

        // 3-beat INCR burst at 0x80, read back streaming and with stalls
        wd[0] = d0; wd[1] = d1; wd[2] = d2;
        do_write(4'd1, 32'h80, 8'd2, 2'b01, 2, {64{1'b1}}, resp, idv, beats);
        chk("w3_bresp", 512'(resp), 512'(2'b00));
        chk("w3_beats", 512'(beats), 512'(3));
        for (int t = 0; t < 2; t++) begin
            do_read(4'd2, 32'h80, 8'd2, 2'b01, t[0], resp, idv, cycles);
            chk("r3_d0", rd[0], d0);
            chk("r3_d1", rd[1], d1);
            chk("r3_d2", rd[2], d2);
            chk("r3_last0", 512'(rl[0]), 512'(0));
            chk("r3_last1", 512'(rl[1]), 512'(0));
            chk("r3_last2", 512'(rl[2]), 512'(1));
            chk("r3_cycles", 512'(cycles), 512'(t == 0 ? 3 : 6));
        end

        // Partial strobe over word 0x80: only bytes 0..15 change
        wd[0] = e;
        do_write(4'd6, 32'h80, 8'd0, 2'b01, 0, 64'h00000000_0000FFFF, resp, idv, beats);
        chk("wstrb_bresp", 512'(resp), 512'(2'b00));
        m = d0;
        m[127:0] = e[127:0];
        do_read(4'd6, 32'h80, 8'd0, 2'b01, 1'b0, resp, idv, cycles);
        chk("wstrb_data", rd[0], m);

        // WRAP burst: SLVERR, 3 beats consumed, RAM untouched
        wd[0] = '1; wd[1] = '1; wd[2] = '1;
        do_write(4'd7, 32'h80, 8'd2, 2'b10, 2, {64{1'b1}}, resp, idv, beats);
        chk("wrap_bresp", 512'(resp), 512'(2'b10));
        chk("wrap_beats", 512'(beats), 512'(3));
        do_read(4'd7, 32'h80, 8'd0, 2'b01, 1'b0, resp, idv, cycles);
        chk("wrap_ram_kept", rd[0], m);
        do_read(4'd8, 32'h40, 8'd0, 2'b10, 1'b0, resp, idv, cycles);
        chk("wrap_rd_zero", rd[0], 512'(0));
        chk("wrap_rd_rresp", 512'(resp), 512'(2'b10));

        // Early wlast on beat 0 of a 3-beat burst
        do_write(4'd9, 32'h100, 8'd2, 2'b01, 0, {64{1'b1}}, resp, idv, beats);
        chk("early_wlast_bresp", 512'(resp), 512'(2'b10));
        chk("early_wlast_beats", 512'(beats), 512'(3));

        // Reset during write beat 1
        wd[0] = d0; wd[1] = d1;
        s_axi_awid = 4'd4; s_axi_awaddr = 32'h100; s_axi_awlen = 8'd2;
        s_axi_awsize = 3'd6; s_axi_awburst = 2'b01; s_axi_awvalid = 1'b1;
        n = 0;
        while (!s_axi_awready && n < 300) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
        s_axi_wvalid = 1'b1; s_axi_wdata = wd[0]; s_axi_wstrb = '1; s_axi_wlast = 1'b0;
        @(posedge clk); #1;
        s_axi_wdata = wd[1];
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_calib", 512'(init_calib_complete), 512'(0));
        chk("mid_rst_wready", 512'(s_axi_wready), 512'(0));
        chk("mid_rst_bvalid", 512'(s_axi_bvalid), 512'(0));
        chk("mid_rst_awready", 512'(s_axi_awready), 512'(0));
        chk("mid_rst_bid", 512'(s_axi_bid), 512'(0));
        chk("mid_rst_rdata", s_axi_rdata, 512'(0));
        rst = 1'b0;
        s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b1;
        saw_b = 1'b0;
        n = 0;
        while (!init_calib_complete && n < 200) begin
            @(posedge clk); #1; n++;
            if (s_axi_bvalid) saw_b = 1'b1;
        end
        s_axi_bready = 1'b0;
        chk("mid_rst_no_b", 512'(saw_b), 512'(0));
        chk("recal_cycles", 512'(n), 512'(100));

        // Fresh transaction after recalibration
        wd[0] = d2;
        do_write(4'd10, 32'h40, 8'd0, 2'b01, 0, {64{1'b1}}, resp, idv, beats);
        chk("post_rst_bresp", 512'(resp), 512'(2'b00));
        chk("post_rst_bid", 512'(idv), 512'(4'd10));
        do_read(4'd11, 32'h40, 8'd0, 2'b01, 1'b0, resp, idv, cycles);
        chk("post_rst_data", rd[0], d2);
        chk("post_rst_rid", 512'(idv), 512'(4'd11));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
